// File: rtl/snake_body_tracker.sv
// Segment store and step sequencer for the snake game: advances the head one grid
// pitch per step request, detects wall and self collisions, and handles growth.
module snake_body_tracker #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 4,
    parameter int STEP     = 10,
    parameter int X_INIT   = 80,
    parameter int Y_INIT   = 30,
    parameter int XSCREEN  = 160,
    parameter int YSCREEN  = 120
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       init_i,
    input  logic [1:0] dir_req_i,
    input  logic       dir_valid_i,
    input  logic       step_i,
    input  logic       grow_i,
    input  logic [3:0] rd_idx_i,
    output logic [7:0] rd_x_o,
    output logic [6:0] rd_y_o,
    output logic [4:0] length_o,
    output logic [7:0] tail_x_o,
    output logic [6:0] tail_y_o,
    output logic       tail_valid_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       dead_o,
    output logic       collide_wall_o,
    output logic       collide_self_o
);

    typedef enum logic [2:0] {IDLE, CHECK, SCAN, SHIFT, DONE} state_t;

    localparam logic signed [8:0] X_MAX     = 9'(XSCREEN - STEP);
    localparam logic signed [7:0] Y_MAX     = 8'(YSCREEN - STEP);
    localparam logic signed [8:0] STEP_X    = 9'(STEP);
    localparam logic signed [7:0] STEP_Y    = 8'(STEP);
    localparam logic [4:0]        MAX_LEN5  = 5'(MAX_LEN);
    localparam logic [4:0]        INIT_LEN5 = 5'(INIT_LEN);
    localparam logic [1:0]        DIR_UP    = 2'b10;

    state_t state_q, state_d;

    logic [7:0] seg_x_q [MAX_LEN];
    logic [6:0] seg_y_q [MAX_LEN];
    logic [7:0] init_x  [MAX_LEN];
    logic [6:0] init_y  [MAX_LEN];
    logic [7:0] shift_x [MAX_LEN];
    logic [6:0] shift_y [MAX_LEN];

    logic [4:0] length_q;
    logic [1:0] cur_dir_q, pend_dir_q;
    logic       grow_pend_q, grow_step_q;
    logic       dead_q, collide_wall_q, collide_self_q;
    logic [7:0] tail_x_q, next_x_q;
    logic [6:0] tail_y_q, next_y_q;
    logic       tail_valid_q;
    logic [3:0] cnt_q;
    logic [4:0] scan_n_q;

    logic signed [8:0] head_x9, nx;
    logic signed [7:0] head_y8, ny;
    logic              wall;
    logic              growing_now;
    logic [4:0]        scan_n;
    logic              scan_hit;
    logic              scan_last;
    logic              rd_hit;

    // Reset image of the snake and the one-position-down shifted image used by SHIFT.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_seg
            if (gi < INIT_LEN) begin : g_init_body
                assign init_x[gi] = 8'(X_INIT);
                assign init_y[gi] = 7'(Y_INIT + gi * STEP);
            end else begin : g_init_empty
                assign init_x[gi] = 8'd0;
                assign init_y[gi] = 7'd0;
            end
            if (gi == 0) begin : g_head
                assign shift_x[gi] = next_x_q;
                assign shift_y[gi] = next_y_q;
            end else begin : g_body
                assign shift_x[gi] = seg_x_q[gi-1];
                assign shift_y[gi] = seg_y_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        head_x9 = $signed({1'b0, seg_x_q[0]});
        head_y8 = $signed({1'b0, seg_y_q[0]});
        nx      = head_x9;
        ny      = head_y8;
        case (pend_dir_q)
            2'b00:   nx = head_x9 + STEP_X;
            2'b01:   ny = head_y8 + STEP_Y;
            2'b10:   ny = head_y8 - STEP_Y;
            default: nx = head_x9 - STEP_X;
        endcase
    end

    assign wall        = nx[8] || (nx > X_MAX) || ny[7] || (ny > Y_MAX);
    // A full snake cannot grow, so the pending apple is simply dropped at SHIFT.
    assign growing_now = grow_pend_q && (length_q < MAX_LEN5);
    assign scan_n      = growing_now ? length_q : (length_q - 5'd1);
    assign scan_hit    = (seg_x_q[cnt_q] == next_x_q) && (seg_y_q[cnt_q] == next_y_q);
    assign scan_last   = ({1'b0, cnt_q} == (scan_n_q - 5'd1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else if (init_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_o  = (state_q != IDLE);
        done_o  = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (step_i && !dead_q) state_d = CHECK;
            end
            CHECK: begin
                if (wall)              state_d = DONE;
                else if (scan_n == '0) state_d = SHIFT;
                else                   state_d = SCAN;
            end
            SCAN: begin
                if (scan_hit)       state_d = DONE;
                else if (scan_last) state_d = SHIFT;
            end
            SHIFT:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seg_x_q        <= init_x;
            seg_y_q        <= init_y;
            length_q       <= INIT_LEN5;
            cur_dir_q      <= DIR_UP;
            pend_dir_q     <= DIR_UP;
            grow_pend_q    <= 1'b0;
            grow_step_q    <= 1'b0;
            dead_q         <= 1'b0;
            collide_wall_q <= 1'b0;
            collide_self_q <= 1'b0;
            tail_x_q       <= 8'd0;
            tail_y_q       <= 7'd0;
            tail_valid_q   <= 1'b0;
            next_x_q       <= 8'd0;
            next_y_q       <= 7'd0;
            cnt_q          <= 4'd0;
            scan_n_q       <= 5'd0;
        end else if (init_i) begin
            seg_x_q        <= init_x;
            seg_y_q        <= init_y;
            length_q       <= INIT_LEN5;
            cur_dir_q      <= DIR_UP;
            pend_dir_q     <= DIR_UP;
            grow_pend_q    <= 1'b0;
            grow_step_q    <= 1'b0;
            dead_q         <= 1'b0;
            collide_wall_q <= 1'b0;
            collide_self_q <= 1'b0;
            tail_x_q       <= 8'd0;
            tail_y_q       <= 7'd0;
            tail_valid_q   <= 1'b0;
            next_x_q       <= 8'd0;
            next_y_q       <= 7'd0;
            cnt_q          <= 4'd0;
            scan_n_q       <= 5'd0;
        end else begin
            // Reversing onto the neck would be an instant self collision, so it is dropped.
            if (dir_valid_i && !((length_q > 5'd1) && (dir_req_i == ~cur_dir_q)))
                pend_dir_q <= dir_req_i;
            case (state_q)
                CHECK: begin
                    cur_dir_q   <= pend_dir_q;
                    next_x_q    <= nx[7:0];
                    next_y_q    <= ny[6:0];
                    grow_step_q <= growing_now;
                    scan_n_q    <= scan_n;
                    cnt_q       <= 4'd0;
                    if (wall) begin
                        dead_q         <= 1'b1;
                        collide_wall_q <= 1'b1;
                        tail_valid_q   <= 1'b0;
                    end
                end
                SCAN: begin
                    if (scan_hit) begin
                        dead_q         <= 1'b1;
                        collide_self_q <= 1'b1;
                        tail_valid_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                SHIFT: begin
                    seg_x_q     <= shift_x;
                    seg_y_q     <= shift_y;
                    grow_pend_q <= 1'b0;
                    if (grow_step_q) begin
                        length_q     <= length_q + 5'd1;
                        tail_valid_q <= 1'b0;
                    end else begin
                        tail_x_q     <= seg_x_q[4'(length_q - 5'd1)];
                        tail_y_q     <= seg_y_q[4'(length_q - 5'd1)];
                        tail_valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (grow_i) grow_pend_q <= 1'b1;
        end
    end

    assign rd_hit         = ({1'b0, rd_idx_i} < length_q);
    assign rd_x_o         = rd_hit ? seg_x_q[rd_idx_i] : 8'd0;
    assign rd_y_o         = rd_hit ? seg_y_q[rd_idx_i] : 7'd0;
    assign length_o       = length_q;
    assign tail_x_o       = tail_x_q;
    assign tail_y_o       = tail_y_q;
    assign tail_valid_o   = tail_valid_q;
    assign dead_o         = dead_q;
    assign collide_wall_o = collide_wall_q;
    assign collide_self_o = collide_self_q;

endmodule

// File: tb/tb_snake_body_tracker.sv
// Bench for snake_body_tracker: a behavioural snake model predicts each step's
// outcome into a scoreboard that is drained when the DUT signals completion.
module tb_snake_body_tracker;

    logic       clk = 1'b0;
    logic       rst_i, init_i, dir_valid_i, step_i, grow_i;
    logic [1:0] dir_req_i;
    logic [3:0] rd_idx_i;
    logic [7:0] rd_x_o, tail_x_o;
    logic [6:0] rd_y_o, tail_y_o;
    logic [4:0] length_o;
    logic       tail_valid_o, busy_o, done_o, dead_o, collide_wall_o, collide_self_o;

    always #5 clk = ~clk;

    snake_body_tracker dut (
        .clk_i(clk), .rst_i(rst_i), .init_i(init_i), .dir_req_i(dir_req_i),
        .dir_valid_i(dir_valid_i), .step_i(step_i), .grow_i(grow_i), .rd_idx_i(rd_idx_i),
        .rd_x_o(rd_x_o), .rd_y_o(rd_y_o), .length_o(length_o), .tail_x_o(tail_x_o),
        .tail_y_o(tail_y_o), .tail_valid_o(tail_valid_o), .busy_o(busy_o), .done_o(done_o),
        .dead_o(dead_o), .collide_wall_o(collide_wall_o), .collide_self_o(collide_self_o)
    );

    typedef struct {
        integer lat, hx, hy, len, tx, ty, tv, dead, cw, cs;
    } res_t;

    res_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference snake: one step is resolved instantly, latency derived from compare count.
    int mx[16], my[16];
    int mlen, mdir, mtx, mty, mgrow, mdead, mtv, mcw, mcs;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mx[i] = (i < 4) ? 80 : 0;
            my[i] = (i < 4) ? 30 + 10 * i : 0;
        end
        mlen = 4; mdir = 2; mgrow = 0; mdead = 0;
        mtx = 0; mty = 0; mtv = 0; mcw = 0; mcs = 0;
    endtask

    task automatic model_step(output res_t e);
        int nx, ny, n, hit, growing;
        e.lat = 0;
        if (!mdead) begin
            nx = mx[0];
            ny = my[0];
            case (mdir)
                0: nx = nx + 10;
                1: ny = ny + 10;
                2: ny = ny - 10;
                default: nx = nx - 10;
            endcase
            if (nx < 0 || nx > 150 || ny < 0 || ny > 110) begin
                mdead = 1; mcw = 1; mtv = 0; e.lat = 2;
            end else begin
                growing = (mgrow != 0 && mlen < 16) ? 1 : 0;
                n = growing ? mlen : mlen - 1;
                hit = -1;
                for (int j = 0; j < n; j++)
                    if (hit < 0 && mx[j] == nx && my[j] == ny) hit = j;
                if (hit >= 0) begin
                    mdead = 1; mcs = 1; mtv = 0; e.lat = 3 + hit;
                end else begin
                    e.lat = 3 + n;
                    if (growing) begin
                        mlen = mlen + 1; mtv = 0;
                    end else begin
                        mtx = mx[mlen-1]; mty = my[mlen-1]; mtv = 1;
                    end
                    for (int i = 15; i > 0; i--) begin
                        mx[i] = mx[i-1];
                        my[i] = my[i-1];
                    end
                    mx[0] = nx; my[0] = ny; mgrow = 0;
                end
            end
        end
        e.hx = mx[0]; e.hy = my[0]; e.len = mlen; e.tx = mtx; e.ty = mty;
        e.tv = mtv; e.dead = mdead; e.cw = mcw; e.cs = mcs;
    endtask

    task automatic rd(input int idx, output integer x, output integer y);
        rd_idx_i = 4'(idx);
        #1;
        x = rd_x_o;
        y = rd_y_o;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic req_dir(input int d);
        @(negedge clk);
        dir_req_i = 2'(d);
        dir_valid_i = 1'b1;
        @(negedge clk);
        dir_valid_i = 1'b0;
        if (!(mlen > 1 && d == 3 - mdir)) mdir = d;
    endtask

    task automatic pulse_grow();
        @(negedge clk);
        grow_i = 1'b1;
        @(negedge clk);
        grow_i = 1'b0;
        mgrow = 1;
    endtask

    // Drives one step request, queues the model prediction, and captures the DUT result.
    task automatic run_step(output res_t o);
        res_t e;
        model_step(e);
        sb.push_back(e);
        @(negedge clk);
        step_i = 1'b1;
        @(negedge clk);
        step_i = 1'b0;
        o.lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done_o) begin
                o.lat = c;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        rd(0, o.hx, o.hy);
        o.len = length_o; o.tx = tail_x_o; o.ty = tail_y_o; o.tv = tail_valid_o;
        o.dead = dead_o; o.cw = collide_wall_o; o.cs = collide_self_o;
        $display("step: done after %0d cycles, head (%0d,%0d) len %0d tail (%0d,%0d) v=%0d dead=%0d",
                 o.lat, o.hx, o.hy, o.len, o.tx, o.ty, o.tv, o.dead);
    endtask

    task automatic test_reset();
        integer x, y;
        do_reset();
        n_vec++;
        if (length_o !== 5'd4) begin n_bad++; $display("FAIL reset_length: got %0d want 4", length_o); end
        rd(0, x, y);
        n_vec++;
        if (x !== 80 || y !== 30) begin n_bad++; $display("FAIL reset_head: got (%0d,%0d) want (80,30)", x, y); end
        rd(3, x, y);
        n_vec++;
        if (x !== 80 || y !== 60) begin n_bad++; $display("FAIL reset_seg3: got (%0d,%0d) want (80,60)", x, y); end
        rd(4, x, y);
        n_vec++;
        if (x !== 0 || y !== 0) begin n_bad++; $display("FAIL reset_seg4: got (%0d,%0d) want (0,0)", x, y); end
        n_vec++;
        if ({busy_o, dead_o, done_o, tail_valid_o} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags: busy/dead/done/tv got %b want 0000", {busy_o, dead_o, done_o, tail_valid_o});
        end
        // Asynchronous reset in the middle of a scan.
        @(negedge clk); step_i = 1'b1;
        @(negedge clk); step_i = 1'b0;
        @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        n_vec++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_async: busy %b done %b want 0 0", busy_o, done_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
        $display("reset: length %0d busy %b", length_o, busy_o);
    endtask

    task automatic test_plain_step();
        res_t o, e;
        integer x, y;
        run_step(o);
        e = sb.pop_front();
        n_vec++;
        if (o.lat !== e.lat) begin n_bad++; $display("FAIL plain_latency: got %0d want %0d", o.lat, e.lat); end
        n_vec++;
        if (o.hx !== e.hx || o.hy !== e.hy) begin n_bad++; $display("FAIL plain_head: got (%0d,%0d) want (%0d,%0d)", o.hx, o.hy, e.hx, e.hy); end
        n_vec++;
        if (o.tx !== e.tx || o.ty !== e.ty || o.tv !== e.tv) begin
            n_bad++; $display("FAIL plain_tail: got (%0d,%0d,v%0d) want (%0d,%0d,v%0d)", o.tx, o.ty, o.tv, e.tx, e.ty, e.tv);
        end
        rd(3, x, y);
        n_vec++;
        if (x !== mx[3] || y !== my[3]) begin n_bad++; $display("FAIL plain_seg3: got (%0d,%0d) want (%0d,%0d)", x, y, mx[3], my[3]); end
    endtask

    task automatic test_turn();
        res_t o, e;
        req_dir(1);
        run_step(o);
        e = sb.pop_front();
        n_vec++;
        if (o.hx !== e.hx || o.hy !== e.hy) begin n_bad++; $display("FAIL reversal_head: got (%0d,%0d) want (%0d,%0d)", o.hx, o.hy, e.hx, e.hy); end
        req_dir(0);
        run_step(o);
        e = sb.pop_front();
        n_vec++;
        if (o.hx !== e.hx || o.hy !== e.hy) begin n_bad++; $display("FAIL turn_head: got (%0d,%0d) want (%0d,%0d)", o.hx, o.hy, e.hx, e.hy); end
    endtask

    task automatic test_growth();
        res_t o, e;
        integer x, y;
        do_reset();
        req_dir(0);
        for (int s = 1; s <= 13; s++) begin
            if (s == 8) req_dir(1);
            pulse_grow();
            run_step(o);
            e = sb.pop_front();
            n_vec++;
            if (o.lat !== e.lat || o.len !== e.len || o.tv !== e.tv) begin
                n_bad++;
                $display("FAIL grow_step%0d: lat/len/tv got %0d/%0d/%0d want %0d/%0d/%0d",
                         s, o.lat, o.len, o.tv, e.lat, e.len, e.tv);
            end
            if (s == 1) begin
                rd(4, x, y);
                n_vec++;
                if (x !== mx[4] || y !== my[4]) begin n_bad++; $display("FAIL grow_seg4: got (%0d,%0d) want (%0d,%0d)", x, y, mx[4], my[4]); end
            end
        end
        rd(15, x, y);
        n_vec++;
        if (x !== mx[15] || y !== my[15]) begin n_bad++; $display("FAIL grow_seg15: got (%0d,%0d) want (%0d,%0d)", x, y, mx[15], my[15]); end
    endtask

    task automatic test_wall();
        res_t o, e;
        do_reset();
        for (int s = 0; s < 5; s++) begin
            run_step(o);
            e = sb.pop_front();
            n_vec++;
            if (o.lat !== e.lat || o.hx !== e.hx || o.hy !== e.hy) begin
                n_bad++;
                $display("FAIL wall_step%0d: lat %0d head (%0d,%0d) want lat %0d head (%0d,%0d)",
                         s, o.lat, o.hx, o.hy, e.lat, e.hx, e.hy);
            end
            if (s == 3) begin
                n_vec++;
                if (o.dead !== e.dead || o.cw !== e.cw || o.cs !== e.cs || o.tv !== e.tv) begin
                    n_bad++;
                    $display("FAIL wall_flags: dead/cw/cs/tv got %0d%0d%0d%0d want %0d%0d%0d%0d",
                             o.dead, o.cw, o.cs, o.tv, e.dead, e.cw, e.cs, e.tv);
                end
            end
        end
    endtask

    task automatic test_self();
        res_t o, e;
        integer x, y;
        int dirs[5] = '{2, 0, 1, 3, 2};
        do_reset();
        for (int s = 0; s < 7; s++) begin
            if (s < 2) pulse_grow();
            else req_dir(dirs[s-2]);
            run_step(o);
            e = sb.pop_front();
            n_vec++;
            if (o.lat !== e.lat || o.len !== e.len || o.dead !== e.dead || o.cs !== e.cs || o.cw !== e.cw) begin
                n_bad++;
                $display("FAIL self_step%0d: lat/len/dead/cs/cw got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
                         s, o.lat, o.len, o.dead, o.cs, o.cw, e.lat, e.len, e.dead, e.cs, e.cw);
            end
        end
        for (int i = 0; i < 6; i++) begin
            rd(i, x, y);
            n_vec++;
            if (x !== mx[i] || y !== my[i]) begin n_bad++; $display("FAIL self_seg%0d: got (%0d,%0d) want (%0d,%0d)", i, x, y, mx[i], my[i]); end
        end
        @(negedge clk); init_i = 1'b1;
        @(negedge clk); init_i = 1'b0;
        model_reset();
        rd(0, x, y);
        n_vec++;
        if (dead_o !== 1'b0 || collide_self_o !== 1'b0 || length_o !== 5'd4 || x !== 80 || y !== 30) begin
            n_bad++;
            $display("FAIL self_init: dead %b cs %b len %0d head (%0d,%0d) want 0 0 4 (80,30)", dead_o, collide_self_o, length_o, x, y);
        end
        $display("init: dead %b length %0d", dead_o, length_o);
    endtask

    task automatic test_back_to_back();
        res_t o, e;
        integer x, y;
        int seen;
        @(negedge clk); step_i = 1'b1;
        @(negedge clk); step_i = 1'b0;
        @(negedge clk); init_i = 1'b1; step_i = 1'b1;
        @(negedge clk); init_i = 1'b0; step_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (done_o) seen = 1;
            @(negedge clk);
        end
        rd(0, x, y);
        n_vec++;
        if (seen !== 0 || busy_o !== 1'b0 || x !== 80 || y !== 30) begin
            n_bad++; $display("FAIL init_abort: done seen %0d busy %b head (%0d,%0d) want 0 0 (80,30)", seen, busy_o, x, y);
        end
        for (int s = 0; s < 2; s++) begin
            run_step(o);
            e = sb.pop_front();
            n_vec++;
            if (o.lat !== e.lat || o.hx !== e.hx || o.hy !== e.hy) begin
                n_bad++; $display("FAIL b2b_step%0d: lat %0d head (%0d,%0d) want lat %0d head (%0d,%0d)", s, o.lat, o.hx, o.hy, e.lat, e.hx, e.hy);
            end
        end
    endtask

    initial begin
        rst_i = 1'b1; init_i = 1'b0; dir_valid_i = 1'b0; step_i = 1'b0;
        grow_i = 1'b0; dir_req_i = 2'b00; rd_idx_i = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_plain_step();
        test_turn();
        test_growth();
        test_wall();
        test_self();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/snake_body_tracker.md
# snake_body_tracker

Holds the position of every snake segment on the 10-pixel grid and advances the snake one grid step per request. Sits directly upstream of the VGA draw/erase FSM: that FSM pulses `step` once per animation tick, waits for `done`, then reads segment coordinates through the indexed read port to draw the body and erase the vacated tail. The block also handles growth on apple capture, wall collision and self collision.

## Interface
- `MAX_LEN`, 16: segment storage depth. Power of 2, ≤ 16.
- `INIT_LEN`, 4: length after reset or `init`.
- `STEP`, 10: grid pitch in pixels. Equals segment XDIM/YDIM.
- `X_INIT`, 80: initial head x.
- `Y_INIT`, 30: initial head y.
- `XSCREEN`, 160: screen width in pixels.
- `YSCREEN`, 120: screen height in pixels.
- `Clock` in 1: system clock (CLOCK_50).
- `Reset` in 1: asynchronous, active-high reset.
- `init` in 1: synchronous reload of the initial snake. Accepted in any state.
- `dir_req` in 2: requested direction. 00 right, 01 down, 10 up, 11 left.
- `dir_valid` in 1: qualifies `dir_req`.
- `step` in 1: one-cycle request to advance one grid step.
- `grow` in 1: one-cycle apple-captured pulse.
- `rd_idx` in 4: segment index to read. 0 is the head.
- `rd_x` out 8: x of segment `rd_idx`. Combinational. Reads 0 when `rd_idx ≥ length`.
- `rd_y` out 7: y of segment `rd_idx`. Same rules as `rd_x`.
- `length` out 5: current segment count.
- `tail_x` out 8, `tail_y` out 7: coordinate vacated by the last successful step.
- `tail_valid` out 1: high when `tail_x`/`tail_y` must be erased.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a step request completes.
- `dead` out 1: sticky collision flag.
- `collide_wall` out 1, `collide_self` out 1: cause of the last collision. Sticky together with `dead`.

## Operation
- **Reset / init value.** Segment i = (`X_INIT`, `Y_INIT` + i·`STEP`) for i < `INIT_LEN`; all other segments = 0.
  - `length` = `INIT_LEN`, current direction = up (10).
  - `busy`, `done`, `dead`, `collide_wall`, `collide_self`, `tail_valid`, grow-pending all 0; `tail_x`/`tail_y` = 0.
  - `init` applies the same values on the next edge and returns the FSM to IDLE.
- **Direction latch.** `dir_valid` updates the pending direction in any state.
  - A request exactly opposite to the current direction is discarded when `length` > 1.
  - The pending direction becomes current in CHECK.
- **Grow latch.** `grow` sets grow-pending in any state. It is consumed by the next step.
  - If `length` = `MAX_LEN`, the pending flag is cleared and the length is unchanged.
- **State machine.** States are IDLE, CHECK, SCAN, SHIFT, DONE.
  - IDLE: `step` with `dead` = 0 → CHECK. `step` while `dead` = 1 or `busy` = 1 is ignored (no `done`).
  - CHECK: compute the next head. Move x = ±`STEP` for right/left, y = ±`STEP` for down/up, using 9-bit/8-bit signed intermediates.
    - Wall collision when next x < 0 or > `XSCREEN`−`STEP`, or next y < 0 or > `YSCREEN`−`STEP`.
    - On wall collision → DONE with `dead` and `collide_wall` set. Otherwise → SCAN with the scan counter = 0.
  - SCAN: compare the next head against segment[counter], one per cycle.
    - Compare n = `length`−1 segments (the tail is excluded because it vacates), or n = `length` when growing.
    - On a match → DONE with `dead` and `collide_self` set, and no shift.
    - When counter = n−1 with no match → SHIFT. When n = 0 → SHIFT directly.
  - SHIFT: segment[i] ← segment[i−1] for i ≥ 1; segment[0] ← next head.
    - Not growing: `tail_x`/`tail_y` ← old segment[`length`−1]; `tail_valid` = 1.
    - Growing: `length` +1; `tail_valid` = 0.
    - Clear grow-pending. → DONE.
  - DONE: `done` = 1. → IDLE.
- **Failed step.** Segments, `length` and tail outputs are unchanged; `tail_valid` is cleared.

## Timing
- `step` sampled high at edge k:
  - CHECK during cycle k+1.
  - SCAN during cycles k+2 … k+1+n.
  - SHIFT during cycle k+2+n.
  - DONE during cycle k+3+n.
  - Example: `INIT_LEN` = 4 gives `done` in cycle k+6.
- Wall collision: `done` in cycle k+2. Self collision at compare index j: `done` in cycle k+3+j.
- Segment registers change only at the edge ending SHIFT. The read port must only be used while `busy` = 0.
- `init` has priority over `step`, `grow` and `dir_valid` in the same cycle.
- `dir_valid` in the CHECK cycle itself takes effect on the following step.
- Asserting `Reset` mid-operation immediately forces the reset values; no `done` is produced.

## Test plan
- **Reset.** Pulse `Reset` → `length` = 4; rd_idx 0 → (80,30); rd_idx 3 → (80,60); rd_idx 4 → (0,0); `busy` = 0, `dead` = 0.
- **Plain step.** `step` → `done` exactly 6 cycles later; head (80,20); segment 3 = (80,50); `tail` = (80,60); `tail_valid` = 1.
- **Reversal and turn.** `dir_req` = down while moving up, then `step` → head (80,10). Then `dir_req` = right, `step` → head (90,10).
- **Growth.** `grow` then `step` → `length` = 5, `tail_valid` = 0, segment 4 = previous tail, `done` 7 cycles after `step`. Repeat to `MAX_LEN`, then `grow`+`step` → `length` stays 16.
- **Wall collision.** From reset, step up 3× (head (80,0)), then `step` → `done` 2 cycles later, `dead` = 1, `collide_wall` = 1, head still (80,0). A further `step` produces no `done`.
- **Self collision.** Grow to `length` 6, then steps right, down, left, up → `collide_self` = 1, segments unchanged. `init` → `dead` cleared and the reset snake restored.
